// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode field placement, reset fetch address and
// the fetch-stage state encoding. The decoder takes its opcode constants from here too.
package cpu_pkg;

   localparam int          OPCODE_W   = 5;
   localparam int          OPCODE_MSB = 15;
   localparam int          OPCODE_LSB = 11;
   localparam logic [15:0] RESET_PC   = 16'h0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/if_id_skid.sv
// Pipeline register with one skid entry. A word that arrives while the output is
// stalled is parked in the skid. It moves to the output once the consumer takes the current word.
module if_id_skid #(
   parameter int DATA_W = 48
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o
);

   logic              out_valid_q, out_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              out_free;

   assign out_free    = !out_valid_q || out_ready_i;
   assign in_ready_o  = !skid_valid_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (out_free) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (in_valid_i) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data_i;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_valid_i && !skid_valid_q) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data_i;
      end
      // A flush drops both entries; the data fields keep their last contents.
      if (flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_data_q   <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_data_q   <= out_data_d;
      end
   end

   always_ff @(posedge clk) begin
      skid_data_q <= skid_data_d;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC and keeps one instruction-memory request in flight.
// Each returned instruction goes to decode through the IF/ID skid register, together with its PC and PC+1.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter int              INSTR_W  = 16,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(cpu_pkg::RESET_PC)
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req,
   output logic [PC_W-1:0]     imem_addr,
   input  logic                imem_gnt,
   input  logic                imem_rvalid,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                redirect_valid,
   input  logic [PC_W-1:0]     redirect_pc,
   input  logic                id_ready,
   output logic                if_id_valid,
   output logic [INSTR_W-1:0]  if_id_instr,
   output logic [OPCODE_W-1:0] if_id_opcode,
   output logic [PC_W-1:0]     if_id_pc,
   output logic [PC_W-1:0]     if_id_pc_plus1
);

   localparam int PKT_W = INSTR_W + 2 * PC_W;

   fetch_state_e     state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]  fetch_pc_inc;
   logic             drop_q, drop_d;
   logic             push, flush, slot_free, skid_in_ready;
   logic [PKT_W-1:0] push_data, out_data;

   assign fetch_pc_inc = fetch_pc_q + PC_W'(1);
   assign slot_free    = !if_id_valid || id_ready;
   assign push_data    = {imem_rdata, fetch_pc_q, fetch_pc_inc};
   assign imem_req     = (state_q == S_REQ);
   assign imem_addr    = pc_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      push       = 1'b0;
      flush      = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (imem_gnt) begin
               state_d    = S_WAIT;
               fetch_pc_d = pc_q;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else if (skid_in_ready) begin
                  push    = 1'b1;
                  pc_d    = fetch_pc_inc;
                  state_d = slot_free ? S_REQ : S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (id_ready) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
      // Redirect overrides everything; a grant or response already under way is marked stale.
      if (redirect_valid) begin
         pc_d  = redirect_pc;
         flush = 1'b1;
         push  = 1'b0;
         case (state_q)
            S_REQ: begin
               if (imem_gnt) begin
                  state_d = S_WAIT;
                  drop_d  = 1'b1;
               end else begin
                  state_d = S_REQ;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  state_d = S_REQ;
                  drop_d  = 1'b0;
               end else begin
                  state_d = S_WAIT;
                  drop_d  = 1'b1;
               end
            end
            default: begin
               state_d = S_REQ;
               drop_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      fetch_pc_q <= fetch_pc_d;
   end

   if_id_skid #(
      .DATA_W (PKT_W)
   ) u_if_id (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .in_valid_i  (push),
      .in_ready_o  (skid_in_ready),
      .in_data_i   (push_data),
      .out_valid_o (if_id_valid),
      .out_ready_i (id_ready),
      .out_data_o  (out_data)
   );

   assign if_id_instr    = out_data[PKT_W-1 -: INSTR_W];
   assign if_id_pc       = out_data[2*PC_W-1 -: PC_W];
   assign if_id_pc_plus1 = out_data[PC_W-1:0];
   assign if_id_opcode   = if_id_instr[INSTR_W-1 -: OPCODE_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency instruction memory model.
// The bench logs every accepted instruction and every granted address.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = 16'h0;
   logic        id_ready = 1'b1;
   logic        if_id_valid;
   logic [15:0] if_id_instr;
   logic [4:0]  if_id_opcode;
   logic [15:0] if_id_pc;
   logic [15:0] if_id_pc_plus1;

   int          n_checks = 0;
   int          n_errors = 0;
   int          lat = 1;
   logic        gnt_en = 1'b1;
   logic        mem_pend;
   int          mem_cnt;
   logic [15:0] mem_addr;
   logic [15:0] acc_pc[$];
   logic [15:0] acc_instr[$];
   logic [15:0] gnt_log[$];

   always #5 clk = ~clk;
   assign imem_gnt = gnt_en;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_id_valid    (if_id_valid),
      .if_id_instr    (if_id_instr),
      .if_id_opcode   (if_id_opcode),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus1 (if_id_pc_plus1)
   );

   function automatic logic [15:0] instr_at(input logic [15:0] a);
      if (a == 16'h0000) return 16'h3841;
      return {a[7:0] ^ 8'h5A, a[7:0]};
   endfunction

   // Memory: response arrives lat cycles after the grant; it shares rst_n.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_pend    <= 1'b0;
         mem_cnt     <= 0;
         mem_addr    <= 16'h0;
         imem_rvalid <= 1'b0;
         imem_rdata  <= 16'h0;
      end else begin
         imem_rvalid <= 1'b0;
         if (mem_pend) begin
            if (mem_cnt == 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= instr_at(mem_addr);
               mem_pend    <= 1'b0;
            end else begin
               mem_cnt <= mem_cnt - 1;
            end
         end
         if (imem_req && imem_gnt) begin
            if (lat == 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= instr_at(imem_addr);
            end else begin
               mem_pend <= 1'b1;
               mem_cnt  <= lat - 1;
               mem_addr <= imem_addr;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n && if_id_valid && id_ready) begin
         acc_pc.push_back(if_id_pc);
         acc_instr.push_back(if_id_instr);
      end
      if (rst_n && imem_req && imem_gnt) gnt_log.push_back(imem_addr);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0;
      repeat (2) @(negedge clk);
      acc_pc.delete();
      acc_instr.delete();
      gnt_log.delete();
      rst_n = 1'b1;
   endtask

   task automatic wait_req(input int max, input string tag);
      int n = 0;
      while (!imem_req && n < max) begin
         @(negedge clk);
         n++;
      end
      if (!imem_req) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_valid(input int max, input string tag);
      int n = 0;
      while (!if_id_valid && n < max) begin
         @(negedge clk);
         n++;
      end
      if (!if_id_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_acc(input int cnt, input int max, input string tag);
      int n = 0;
      while (acc_pc.size() < cnt && n < max) begin
         @(negedge clk);
         n++;
      end
      if (acc_pc.size() < cnt) chk({tag, "_timeout"}, 32'(acc_pc.size()), 32'(cnt));
   endtask

   initial begin
      logic [15:0] exp_i[4];
      int          n;
      logic        saw;
      exp_i = '{16'h3841, 16'h5B01, 16'h5802, 16'h5903};

      // Test 1: reset values, first fetch, sequential stream
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", if_id_valid, 1'b0);
      chk("rst_instr", if_id_instr, 16'h0);
      chk("rst_pc", if_id_pc, 16'h0);
      chk("rst_pc1", if_id_pc_plus1, 16'h0);
      rst_n = 1'b1;
      chk("t1_idle_req", imem_req, 1'b0);
      @(negedge clk);
      chk("t1_req", imem_req, 1'b1);
      chk("t1_addr", imem_addr, 16'h0000);
      @(negedge clk);
      chk("t1_wait_req", imem_req, 1'b0);
      chk("t1_wait_valid", if_id_valid, 1'b0);
      @(negedge clk);
      chk("t1_valid", if_id_valid, 1'b1);
      chk("t1_instr", if_id_instr, 16'h3841);
      chk("t1_opcode", if_id_opcode, 5'b00111);
      chk("t1_pc", if_id_pc, 16'h0000);
      chk("t1_pc1", if_id_pc_plus1, 16'h0001);
      chk("t1_next_addr", imem_addr, 16'h0001);
      wait_acc(4, 20, "t1_acc");
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_acc_pc%0d", i), acc_pc[i], 16'(i));
         chk($sformatf("t1_acc_in%0d", i), acc_instr[i], exp_i[i]);
      end

      // Test 2: consumer stall parks the next word in the skid
      do_reset();
      lat = 1;
      id_ready = 1'b1;
      wait_valid(10, "t2_valid");
      id_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("t2_hold_v%0d", i), if_id_valid, 1'b1);
         chk($sformatf("t2_hold_pc%0d", i), if_id_pc, 16'h0000);
         chk($sformatf("t2_hold_in%0d", i), if_id_instr, 16'h3841);
      end
      chk("t2_no_req", imem_req, 1'b0);
      chk("t2_gnt_cnt", 32'(gnt_log.size()), 32'd2);
      chk("t2_no_acc", 32'(acc_pc.size()), 32'd0);
      id_ready = 1'b1;
      wait_acc(3, 20, "t2_acc");
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t2_acc_pc%0d", i), acc_pc[i], 16'(i));
         chk($sformatf("t2_acc_in%0d", i), acc_instr[i], exp_i[i]);
      end

      // Test 3: redirect while waiting on a slow response
      do_reset();
      lat = 3;
      id_ready = 1'b1;
      wait_req(10, "t3_req0");
      @(negedge clk);
      chk("t3_in_wait", imem_req, 1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0040;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("t3_still_wait", imem_req, 1'b0);
      saw = 1'b0;
      n   = 0;
      while (!imem_req && n < 10) begin
         saw |= if_id_valid;
         @(negedge clk);
         n++;
      end
      chk("t3_no_valid", saw, 1'b0);
      chk("t3_req_delay", 32'(n), 32'd2);
      chk("t3_req_addr", imem_addr, 16'h0040);
      wait_acc(1, 20, "t3_acc");
      chk("t3_acc_pc", acc_pc[0], 16'h0040);
      chk("t3_acc_in", acc_instr[0], 16'h1A40);

      // Test 4: redirect coinciding with a grant and a consumer handshake
      do_reset();
      lat = 1;
      id_ready = 1'b1;
      wait_valid(10, "t4_valid");
      chk("t4_req_hi", imem_req, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0100;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("t4_valid_fall", if_id_valid, 1'b0);
      chk("t4_wait", imem_req, 1'b0);
      chk("t4_hs_done", 32'(acc_pc.size()), 32'd1);
      chk("t4_hs_pc", acc_pc[0], 16'h0000);
      @(negedge clk);
      chk("t4_req", imem_req, 1'b1);
      chk("t4_addr", imem_addr, 16'h0100);
      chk("t4_dropped", if_id_valid, 1'b0);
      wait_acc(2, 20, "t4_acc");
      chk("t4_acc_pc", acc_pc[1], 16'h0100);
      chk("t4_acc_in", acc_instr[1], 16'h5A00);

      // Test 5: fetch at the top of the address space wraps
      do_reset();
      gnt_en = 1'b0;
      wait_req(10, "t5_req");
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFF;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("t5_req_kept", imem_req, 1'b1);
      chk("t5_addr", imem_addr, 16'hFFFF);
      chk("t5_no_gnt", 32'(gnt_log.size()), 32'd0);
      gnt_en = 1'b1;
      wait_valid(10, "t5_valid");
      chk("t5_pc", if_id_pc, 16'hFFFF);
      chk("t5_pc1", if_id_pc_plus1, 16'h0000);
      chk("t5_instr", if_id_instr, 16'hA5FF);
      chk("t5_opcode", if_id_opcode, 5'b10100);
      chk("t5_next_addr", imem_addr, 16'h0000);
      chk("t5_next_req", imem_req, 1'b1);

      // Test 6: asynchronous reset in the middle of a fetch
      do_reset();
      lat = 3;
      id_ready = 1'b0;
      wait_valid(20, "t6_valid");
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_async_req", imem_req, 1'b0);
      chk("t6_async_valid", if_id_valid, 1'b0);
      chk("t6_async_pc", if_id_pc, 16'h0000);
      repeat (2) @(negedge clk);
      acc_pc.delete();
      acc_instr.delete();
      gnt_log.delete();
      id_ready = 1'b1;
      rst_n    = 1'b1;
      chk("t6_idle", imem_req, 1'b0);
      @(negedge clk);
      chk("t6_req", imem_req, 1'b1);
      chk("t6_addr", imem_addr, 16'h0000);
      wait_acc(1, 20, "t6_acc");
      chk("t6_acc_pc", acc_pc[0], 16'h0000);
      chk("t6_acc_in", acc_instr[0], 16'h3841);
      chk("t6_gnt0", gnt_log[0], 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
